shift_register_ctrl: RTL and testbench
======================================

# shift_register_ctrl

Frame sequencer for the `shift_register` datapath (N-bit, right-shifting, LSB-first). It accepts one N-bit word per valid/ready handshake and parallel-loads it into the shift register. It then issues N shift pulses at a programmable rate, so the word leaves on `serial_out` while N bits arrive on `serial_in`, and returns the received word with a one-cycle valid pulse. It sits between a word-level producer/consumer and the shift register instance; the top level ties the register's `rst_n` to `~rst`.

## Interface
- `N`, default 4: word width; must match the shift register; N ≥ 2.
- `DIV`, default 1: cycles per shift pulse; DIV ≥ 1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  N  word to transmit.
- `sr_serial_parallel`  out  1  to shift register: 1 = parallel load, 0 = shift.
- `sr_load_enable`  out  1  to shift register: the register updates only when this is 1.
- `sr_parallel_in`  out  N  to shift register: word to load.
- `sr_parallel_out`  in  N  from shift register: current contents.
- `out_valid`  out  1  one-cycle pulse: `out_data` holds a new received word.
- `out_data`  out  N  last received word; held until the next frame completes.
- `busy`  out  1  a frame is in progress (not IDLE).

## Operation
- **Controlled register behaviour:**
  - load: `sr_serial_parallel`=1 and `sr_load_enable`=1 gives contents = `parallel_in`.
  - shift: `sr_serial_parallel`=0 and `sr_load_enable`=1 gives contents = {serial_in, contents[N-1:1]}.
  - `serial_out` = contents[0].
- **FSM states:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - `in_ready`=1, `busy`=0.
  - On `in_valid`: latch `in_data` into the holding register that drives `sr_parallel_in`, then go to LOAD.
- **LOAD (1 cycle):**
  - `sr_serial_parallel`=1 and `sr_load_enable`=1.
  - Load the divider counter with DIV-1 and the bit counter with 0, then go to SHIFT.
- **SHIFT:**
  - Divider counts down each cycle. When it reaches 0:
    - assert a one-cycle shift pulse (`sr_load_enable`=1, `sr_serial_parallel`=0);
    - reload the divider with DIV-1;
    - increment the bit counter.
  - On the pulse where the bit counter equals N-1, go to DONE.
- **DONE (1 cycle):** register `out_data` <= `sr_parallel_out`, set `out_valid` for the next cycle, then go to IDLE.
- **Default outputs:** outside LOAD and shift pulses, `sr_load_enable`=0 and `sr_serial_parallel`=0.
- **Handshake:**
  - Transfer occurs when `in_valid` && `in_ready`.
  - `in_ready`=0 from LOAD through DONE. `in_valid` and `in_data` are ignored while not ready; words are never queued.
- **Bit order:**
  - Transmit is LSB first.
  - The first received bit ends in `out_data[0]` and the last in `out_data[N-1]`.
- **Counter widths:** bit counter is $clog2(N) bits, divider is $clog2(DIV)+1 bits. Neither wraps inside a frame.

## Timing
- **Reset values:**
  - State = IDLE, so `in_ready`=1 and `busy`=0.
  - `out_valid`=0, `out_data`=0.
  - `sr_load_enable`=0, `sr_serial_parallel`=0, `sr_parallel_in`=0.
- **Cycle schedule, with the accept cycle = t:**
  - LOAD at t+1.
  - Shift pulses at t+1+k·DIV for k = 1..N.
  - DONE at t+2+N·DIV.
  - `out_valid`=1, with new `out_data`, and `in_ready`=1 at t+3+N·DIV.
- **Throughput:** the next word is accepted at the earliest at t+3+N·DIV, the same cycle `out_valid` pulses. A new frame's `out_valid` never overlaps the previous one.
- **Pulse counts:** `sr_load_enable` is high exactly N+1 cycles per frame (1 load + N shifts).
- **Reset mid-frame:**
  - Outputs return to reset values immediately (asynchronous).
  - The frame is discarded and no `out_valid` is issued.
  - After reset, the controller behaves as in IDLE.
- **`in_valid` during DONE:** ignored. It is accepted in the following IDLE cycle if still asserted.

## Test plan
- **Reset:** assert `rst` mid-cycle -> `in_ready`=1, `busy`=0, `out_valid`=0, `sr_load_enable`=0, `out_data`=0 without waiting for a clock edge.
- **Basic loopback (N=4, DIV=1):** `serial_out` looped to `serial_in`, `in_data`=4'b1011 accepted at t -> `serial_out` after each pulse reads 1,1,0,1 (LSB first); `out_valid` only at t+7 with `out_data`=4'b1011; `sr_load_enable` high 5 cycles.
- **Divided rate (N=4, DIV=3):** accept at t -> shift pulses exactly at t+4, t+7, t+10, t+13; `out_valid` at t+15; `busy` high t+1..t+14.
- **Back-to-back and held `in_valid`:** `in_valid` held high with `in_data` changing each cycle -> second word accepted at t+7 (N=4, DIV=1) equals `in_data` at that cycle; intermediate values ignored.
- **Reset mid-frame:** `rst` pulsed after the 2nd shift pulse -> no `out_valid`. A following frame with `in_data`=4'hA and `serial_in`=0 gives `out_data`=4'h0 and `serial_out` sequence 0,1,0,1.
- **Receive independence:** `in_data`=4'hF, `serial_in` driven 1,0,0,1 on successive pulses -> `out_data`=4'b1001.

Source files
------------

// File: rtl/shift_register_ctrl.sv
// Frame sequencer for an N-bit LSB-first shift register: loads one word,
// issues N shift pulses every DIV cycles, then returns the received word.
module shift_register_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         sr_serial_parallel,
    output logic         sr_load_enable,
    output logic [N-1:0] sr_parallel_in,
    input  logic [N-1:0] sr_parallel_out,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_TOP  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic          UNIT_DIV = (DIV == 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;

    // Load enable is registered, so each branch decides whether the
    // *next* cycle is a shift pulse (divider about to reach zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            div_cnt            <= '0;
            bit_cnt            <= '0;
            in_ready           <= 1'b1;
            busy               <= 1'b0;
            sr_serial_parallel <= 1'b0;
            sr_load_enable     <= 1'b0;
            sr_parallel_in     <= '0;
            out_valid          <= 1'b0;
            out_data           <= '0;
        end else begin
            out_valid          <= 1'b0;
            sr_serial_parallel <= 1'b0;
            sr_load_enable     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr_parallel_in     <= in_data;
                        sr_serial_parallel <= 1'b1;
                        sr_load_enable     <= 1'b1;
                        in_ready           <= 1'b0;
                        busy               <= 1'b1;
                        state              <= LOAD;
                    end
                end
                LOAD: begin
                    div_cnt        <= DIV_TOP;
                    bit_cnt        <= '0;
                    sr_load_enable <= UNIT_DIV;
                    state          <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= DONE;
                        end else begin
                            bit_cnt        <= bit_cnt + 1'b1;
                            div_cnt        <= DIV_TOP;
                            sr_load_enable <= UNIT_DIV;
                        end
                    end else begin
                        div_cnt        <= div_cnt - 1'b1;
                        sr_load_enable <= (div_cnt == DIV_ONE);
                    end
                end
                DONE: begin
                    out_data  <= sr_parallel_out;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Two controllers (DIV=1 and DIV=3) each driving a modelled shift register,
// compared every cycle against a frame-offset model plus literal checks.
module tb_shift_register_ctrl;

    localparam int N  = 4;
    localparam int DA = 1;
    localparam int DB = 3;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data  = '0;
    logic         loop     = 1'b1;
    logic [N-1:0] pat      = '0;

    logic [1:0]   in_ready, ssp, sle, ov, busy;
    logic [N-1:0] spin  [2];
    logic [N-1:0] odata [2];
    logic [N-1:0] sreg  [2];
    logic [1:0]   pc    [2];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_register_ctrl #(.N(N), .DIV(DA)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .sr_serial_parallel(ssp[0]), .sr_load_enable(sle[0]),
        .sr_parallel_in(spin[0]), .sr_parallel_out(sreg[0]),
        .out_valid(ov[0]), .out_data(odata[0]), .busy(busy[0])
    );

    shift_register_ctrl #(.N(N), .DIV(DB)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .sr_serial_parallel(ssp[1]), .sr_load_enable(sle[1]),
        .sr_parallel_in(spin[1]), .sr_parallel_out(sreg[1]),
        .out_valid(ov[1]), .out_data(odata[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h at cycle %0d",
                     nm, inst, got, exp, cyc);
        end
    endtask

    // Shift register datapath driven by each controller.
    function automatic logic rx_bit(input int i);
        return loop ? sreg[i][0] : pat[pc[i]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sreg[i] <= '0;
                pc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sle[i]) begin
                    if (ssp[i]) begin
                        sreg[i] <= spin[i];
                        pc[i]   <= '0;
                    end else begin
                        sreg[i] <= {rx_bit(i), sreg[i][N-1:1]};
                        pc[i]   <= pc[i] + 2'd1;
                    end
                end
            end
        end
    end

    // Frame model: everything follows from the accept cycle and DIV.
    int           acc  [2];
    bit           act  [2];
    logic [N-1:0] wrd  [2];
    logic [N-1:0] rx   [2];
    logic [N-1:0] eout [2];

    function automatic int dv(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    function automatic int off(input int i);
        return cyc - acc[i];
    endfunction

    function automatic bit in_frame(input int i);
        return act[i] && off(i) >= 1 && off(i) <= 2 + N * dv(i);
    endfunction

    function automatic bit e_le(input int i);
        return act[i] && off(i) >= 1 && off(i) <= 1 + N * dv(i)
               && ((off(i) - 1) % dv(i)) == 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                act[i]  <= 1'b0;
                wrd[i]  <= '0;
                eout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] && off(i) == 2 + N * dv(i))
                    eout[i] <= rx[i];
                if (!in_frame(i) && in_valid) begin
                    act[i] <= 1'b1;
                    acc[i] <= cyc;
                    wrd[i] <= in_data;
                    rx[i]  <= loop ? in_data : pat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("in_ready", i, in_ready[i], !in_frame(i));
                chk("busy", i, busy[i], in_frame(i));
                chk("load_en", i, sle[i], e_le(i));
                chk("ser_par", i, ssp[i], act[i] && off(i) == 1);
                chk("out_valid", i, ov[i], act[i] && off(i) == 3 + N * dv(i));
                chk("out_data", i, odata[i], eout[i]);
                chk("par_in", i, spin[i], wrd[i]);
            end
        end
    end

    // Event logs for the literal expectations.
    int so0[$], le0[$], ovc0[$], ovd0[$];
    int pc1[$], ovc1[$], ovd1[$], bz1[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (sle[0] && !ssp[0]) so0.push_back(int'(sreg[0][0]));
            if (sle[0]) le0.push_back(cyc);
            if (ov[0]) begin
                ovc0.push_back(cyc);
                ovd0.push_back(int'(odata[0]));
            end
            if (sle[1] && !ssp[1]) pc1.push_back(cyc);
            if (ov[1]) begin
                ovc1.push_back(cyc);
                ovd1.push_back(int'(odata[1]));
            end
            if (busy[1]) bz1.push_back(cyc);
        end
    end

    function automatic int qat(input int q[$], input int k);
        return (k >= 0 && k < q.size()) ? q[k] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] w, output int t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready[0] && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, in_ready[0], 1);
        t = cyc;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic rst_chk();
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", i, in_ready[i], 1);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_out_valid", i, ov[i], 0);
            chk("rst_load_en", i, sle[i], 0);
            chk("rst_ser_par", i, ssp[i], 0);
            chk("rst_out_data", i, odata[i], 0);
            chk("rst_par_in", i, spin[i], 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s0, s1, s2, s3, s4, s5;
        int e4 [4];
        logic [N-1:0] tbl [9];

        #1 rst = 1'b1;
        #2 rst_chk();
        tick(2);
        rst = 1'b0;
        tick(2);

        // Loopback 4'b1011 on both rates.
        s0 = so0.size(); s1 = le0.size(); s2 = ovc0.size();
        s3 = pc1.size(); s4 = ovc1.size(); s5 = bz1.size();
        send(4'b1011, t);
        tick(20);
        e4 = '{1, 1, 0, 1};
        for (int k = 0; k < 4; k++) chk("so_seq", 0, qat(so0, s0 + k), e4[k]);
        chk("so_cnt", 0, so0.size() - s0, 4);
        chk("le_cnt", 0, le0.size() - s1, 5);
        chk("le_first", 0, qat(le0, s1), t + 1);
        chk("ov_cnt", 0, ovc0.size() - s2, 1);
        chk("ov_cyc", 0, qat(ovc0, s2), t + 7);
        chk("ov_data", 0, qat(ovd0, s2), 'hB);
        e4 = '{4, 7, 10, 13};
        for (int k = 0; k < 4; k++) chk("pulse_cyc", 1, qat(pc1, s3 + k), t + e4[k]);
        chk("pulse_cnt", 1, pc1.size() - s3, 4);
        chk("ov_cyc", 1, qat(ovc1, s4), t + 15);
        chk("ov_data", 1, qat(ovd1, s4), 'hB);
        chk("busy_cnt", 1, bz1.size() - s5, 14);
        chk("busy_first", 1, qat(bz1, s5), t + 1);

        // Asynchronous reset after the second shift pulse.
        s2 = ovc0.size(); s4 = ovc1.size();
        send(4'h6, t);
        tick(3);
        #2 rst = 1'b1;
        #1 rst_chk();
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("ov_after_rst", 0, ovc0.size() - s2, 0);
        chk("ov_after_rst", 1, ovc1.size() - s4, 0);

        // Frame 4'hA with serial_in held at zero.
        loop = 1'b0;
        pat  = 4'h0;
        s0 = so0.size(); s2 = ovc0.size(); s4 = ovc1.size();
        send(4'hA, t);
        tick(20);
        e4 = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) chk("so_seq_a", 0, qat(so0, s0 + k), e4[k]);
        chk("ov_cnt_a", 0, ovc0.size() - s2, 1);
        chk("ov_data_a", 0, qat(ovd0, s2), 'h0);
        chk("ov_data_a", 1, qat(ovd1, s4), 'h0);

        // Held in_valid with in_data changing every cycle.
        loop = 1'b1;
        tbl  = '{4'h3, 4'h5, 4'h9, 4'hC, 4'hE, 4'h1, 4'h7, 4'h2, 4'h4};
        s2 = ovc0.size(); s4 = ovc1.size();
        t = cyc;
        in_valid = 1'b1;
        for (int j = 0; j < 9; j++) begin
            in_data = tbl[j];
            tick(1);
        end
        in_valid = 1'b0;
        chk("b2b_par_in", 0, spin[0], 4'h2);
        tick(20);
        chk("b2b_ov_cnt", 0, ovc0.size() - s2, 2);
        chk("b2b_ov_cyc0", 0, qat(ovc0, s2), t + 7);
        chk("b2b_ov_cyc1", 0, qat(ovc0, s2 + 1), t + 14);
        chk("b2b_data0", 0, qat(ovd0, s2), 'h3);
        chk("b2b_data1", 0, qat(ovd0, s2 + 1), 'h2);
        chk("b2b_ov_cnt", 1, ovc1.size() - s4, 1);
        chk("b2b_data0", 1, qat(ovd1, s4), 'h3);

        // Receive path independent of the transmitted word.
        loop = 1'b0;
        pat  = 4'b1001;
        s0 = so0.size(); s2 = ovc0.size(); s4 = ovc1.size();
        send(4'hF, t);
        tick(20);
        for (int k = 0; k < 4; k++) chk("so_seq_f", 0, qat(so0, s0 + k), 1);
        chk("rx_data", 0, qat(ovd0, s2), 'h9);
        chk("rx_data", 1, qat(ovd1, s4), 'h9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
